// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade sequencer: drives a pwm register bus and ramps the duty from its current
// value to a latched target in clamped steps, one high/low byte write pair per step.
module pwm_fade_ctrl #(
    parameter int unsigned PWM_BITS  = 10,
    parameter int unsigned TICK_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [PWM_BITS-1:0]  target_i,
    input  logic [PWM_BITS-1:0]  step_i,
    input  logic [TICK_BITS-1:0] interval_i,
    input  logic [1:0]           ss_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [PWM_BITS-1:0]  duty_o,
    output logic [7:0]           p_addr_o,
    output logic [7:0]           p_data_o,
    output logic                 p_write_o
);

    typedef enum logic [2:0] {StIdle, StCfg, StWait, StWrHi, StWrLo, StDone} state_e;

    state_e               r_state_q, w_state_d;
    logic [PWM_BITS-1:0]  r_cur_q, w_cur_d;
    logic [PWM_BITS-1:0]  r_target_q, w_target_d;
    logic [PWM_BITS-1:0]  r_step_q, w_step_d;
    logic [PWM_BITS-1:0]  w_next;
    logic [TICK_BITS-1:0] r_int_q, w_int_d;
    logic [TICK_BITS-1:0] r_tick_q, w_tick_d;
    logic [1:0]           r_ss_q, w_ss_d;
    logic                 r_abort_pend_q, w_abort_pend_d;
    logic                 w_abort;

    logic                 r_busy, r_done, r_write;
    logic [7:0]           r_addr, r_data;
    logic                 w_busy, w_done, w_write;
    logic [7:0]           w_addr, w_data;

    assign w_abort = abort_i | r_abort_pend_q;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state_q <= StIdle;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            StIdle: if (start_i) w_state_d = StCfg;
            StCfg:  w_state_d = (r_cur_q == r_target_q) ? StWrHi : StWait;
            StWait: begin
                if (w_abort) begin
                    w_state_d = StIdle;
                end else if (r_tick_q == TICK_BITS'(1)) begin
                    w_state_d = StWrHi;
                end
            end
            StWrHi: w_state_d = StWrLo;
            // A pending abort is honoured only after the low byte, so the duty is never torn.
            StWrLo: begin
                if (w_abort) begin
                    w_state_d = StIdle;
                end else if (r_cur_q == r_target_q) begin
                    w_state_d = StDone;
                end else begin
                    w_state_d = StWait;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Clamped step toward the target; never overshoots and never wraps.
    always_comb begin
        w_next = r_cur_q;
        if (r_cur_q < r_target_q) begin
            w_next = (r_target_q - r_cur_q <= r_step_q) ? r_target_q : r_cur_q + r_step_q;
        end else if (r_cur_q > r_target_q) begin
            w_next = (r_cur_q - r_target_q <= r_step_q) ? r_target_q : r_cur_q - r_step_q;
        end
    end

    always_comb begin
        w_target_d     = r_target_q;
        w_step_d       = r_step_q;
        w_int_d        = r_int_q;
        w_ss_d         = r_ss_q;
        w_tick_d       = r_tick_q;
        w_cur_d        = r_cur_q;
        w_abort_pend_d = r_abort_pend_q;

        if (r_state_q == StIdle && start_i) begin
            w_target_d = target_i;
            w_step_d   = (step_i == '0) ? PWM_BITS'(1) : step_i;
            w_int_d    = (interval_i == '0) ? TICK_BITS'(1) : interval_i;
            w_ss_d     = ss_i;
        end

        if (w_state_d == StWait && r_state_q != StWait) begin
            w_tick_d = r_int_q;
        end else if (r_state_q == StWait) begin
            w_tick_d = r_tick_q - TICK_BITS'(1);
        end

        if (r_state_q == StWait && w_state_d == StWrHi) begin
            w_cur_d = w_next;
        end

        if (w_state_d == StIdle) begin
            w_abort_pend_d = 1'b0;
        end else if (r_state_q != StIdle && abort_i) begin
            w_abort_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_target_q     <= '0;
            r_step_q       <= '0;
            r_int_q        <= '0;
            r_ss_q         <= '0;
            r_tick_q       <= '0;
            r_cur_q        <= '0;
            r_abort_pend_q <= 1'b0;
        end else begin
            r_target_q     <= w_target_d;
            r_step_q       <= w_step_d;
            r_int_q        <= w_int_d;
            r_ss_q         <= w_ss_d;
            r_tick_q       <= w_tick_d;
            r_cur_q        <= w_cur_d;
            r_abort_pend_q <= w_abort_pend_d;
        end
    end

    // Outputs decoded from the next state so the registered bus lines up with the state.
    always_comb begin
        w_write = 1'b0;
        w_addr  = 8'h00;
        w_data  = 8'h00;
        w_busy  = (w_state_d != StIdle);
        w_done  = (w_state_d == StDone);
        case (w_state_d)
            StCfg: begin
                w_write = 1'b1;
                w_addr  = 8'h00;
                w_data  = {1'b1, 5'b0, w_ss_d};
            end
            StWrHi: begin
                w_write = 1'b1;
                w_addr  = 8'h01;
                w_data  = 8'(w_cur_d >> 8);
            end
            StWrLo: begin
                w_write = 1'b1;
                w_addr  = 8'h10;
                w_data  = w_cur_d[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 8'h00;
            r_data  <= 8'h00;
        end else begin
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_write <= w_write;
            r_addr  <= w_addr;
            r_data  <= w_data;
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign duty_o    = r_cur_q;
    assign p_write_o = r_write;
    assign p_addr_o  = r_addr;
    assign p_data_o  = r_data;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: a per-cycle expected bus trace is derived from the
// ramp rules (list of clamped duty values, fixed step period) and compared cycle by cycle.
module tb_pwm_fade_ctrl;

    localparam int PB     = 10;
    localparam int TB     = 16;
    localparam int MAXOFF = 512;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start_i, abort_i;
    logic [PB-1:0] target_i, step_i;
    logic [TB-1:0] interval_i;
    logic [1:0]    ss_i;
    logic          busy_o, done_o, p_write_o;
    logic [PB-1:0] duty_o;
    logic [7:0]    p_addr_o, p_data_o;

    pwm_fade_ctrl #(.PWM_BITS(PB), .TICK_BITS(TB)) dut (
        .clk_i     (clk),
        .nrst_i    (nrst),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .target_i  (target_i),
        .step_i    (step_i),
        .interval_i(interval_i),
        .ss_i      (ss_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .duty_o    (duty_o),
        .p_addr_o  (p_addr_o),
        .p_data_o  (p_data_o),
        .p_write_o (p_write_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int model_cur = 0;

    // Expected trace, indexed by cycles after the edge that accepted start.
    logic          e_wr   [MAXOFF];
    logic [7:0]    e_addr [MAXOFF];
    logic [7:0]    e_data [MAXOFF];
    logic          e_done [MAXOFF];
    logic          e_busy [MAXOFF];
    logic [PB-1:0] e_duty [MAXOFF];
    int            e_len;

    function automatic void build_model(int cur, int tgt, int stp, int iv, int ss);
        int st, ivv, w, per, c, hi, done_t;
        int vals[$];
        st  = (stp == 0) ? 1 : stp;
        ivv = (iv == 0) ? 1 : iv;
        c   = cur;
        if (c == tgt) begin
            vals.push_back(c);
        end else begin
            while (c != tgt) begin
                if (c < tgt) c = (tgt - c <= st) ? tgt : c + st;
                else         c = (c - tgt <= st) ? tgt : c - st;
                vals.push_back(c);
            end
        end
        w      = (cur == tgt) ? 0 : ivv;
        per    = w + 2;
        done_t = vals.size() * per + 1;
        e_len  = done_t + 2;
        for (int t = 0; t < MAXOFF; t++) begin
            e_wr[t]   = 1'b0;
            e_addr[t] = 8'h00;
            e_data[t] = 8'h00;
            e_done[t] = (t == done_t);
            e_busy[t] = (t <= done_t);
            e_duty[t] = PB'(cur);
        end
        e_wr[0]   = 1'b1;
        e_data[0] = 8'h80 | 8'(ss);
        for (int k = 0; k < vals.size(); k++) begin
            hi            = (k + 1) * per - 1;
            e_wr[hi]      = 1'b1;
            e_addr[hi]    = 8'h01;
            e_data[hi]    = 8'(vals[k] >> 8);
            e_wr[hi+1]    = 1'b1;
            e_addr[hi+1]  = 8'h10;
            e_data[hi+1]  = 8'(vals[k] & 255);
            for (int t = hi; t < MAXOFF; t++) e_duty[t] = PB'(vals[k]);
        end
    endfunction

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(int tgt, int stp, int iv, int ss);
        target_i   = PB'(tgt);
        step_i     = PB'(stp);
        interval_i = TB'(iv);
        ss_i       = 2'(ss);
        start_i    = 1'b1;
        clk_step();
        start_i    = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; start_i = 0; abort_i = 0; target_i = 0; step_i = 0; interval_i = 0; ss_i = 0;
        repeat (2) clk_step();
        n_tests++;
        if ({busy_o, done_o, p_write_o, p_addr_o, p_data_o, duty_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b wr=%b addr=%h data=%h duty=%h, want all 0",
                     busy_o, done_o, p_write_o, p_addr_o, p_data_o, duty_o);
        end
        nrst = 1'b1;
        clk_step();
        n_tests++;
        if ({busy_o, done_o, p_write_o, duty_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b done=%b wr=%b duty=%h, want all 0",
                     busy_o, done_o, p_write_o, duty_o);
        end
    endtask

    // Directed ramps from the test plan, then random ramps with mid-ramp start/input glitches.
    task automatic test_ramps(int n_rand);
        int d_tgt[5] = '{2, 0, 'h3FF, 5, 5};
        int d_st [5] = '{0, 3, 'h100, 'h200, 7};
        int d_iv [5] = '{0, 2, 3, 1, 2};
        int d_ss [5] = '{1, 3, 2, 0, 1};
        for (int i = 0; i < 5 + n_rand; i++) begin
            int tgt, stp, iv, ss, glitch;
            if (i < 5) begin
                tgt = d_tgt[i]; stp = d_st[i]; iv = d_iv[i]; ss = d_ss[i];
            end else begin
                tgt = ($urandom_range(0, 5) == 0) ? model_cur : int'($urandom_range(0, 1023));
                stp = int'($urandom_range(32, 1023));
                iv  = int'($urandom_range(0, 4));
                ss  = int'($urandom_range(0, 3));
            end
            build_model(model_cur, tgt, stp, iv, ss);
            glitch = (i < 5) ? -1 : int'($urandom_range(0, e_len - 2));
            do_start(tgt, stp, iv, ss);
            for (int t = 0; t < e_len; t++) begin
                n_tests++;
                if (p_write_o !== e_wr[t] || p_addr_o !== e_addr[t] || p_data_o !== e_data[t] ||
                    done_o !== e_done[t] || busy_o !== e_busy[t] || duty_o !== e_duty[t]) begin
                    n_fail++;
                    $display("FAIL ramp%0d t=%0d: got wr=%b a=%h d=%h done=%b busy=%b duty=%h, want wr=%b a=%h d=%h done=%b busy=%b duty=%h",
                             i, t, p_write_o, p_addr_o, p_data_o, done_o, busy_o, duty_o,
                             e_wr[t], e_addr[t], e_data[t], e_done[t], e_busy[t], e_duty[t]);
                end
                if (t == glitch) begin
                    start_i    = 1'b1;
                    target_i   = PB'($urandom);
                    step_i     = PB'($urandom);
                    interval_i = TB'($urandom_range(0, 3));
                end else begin
                    start_i = 1'b0;
                end
                clk_step();
            end
            start_i   = 1'b0;
            model_cur = tgt;
        end
    endtask

    // Case 0: abort while waiting; case 1: abort during the high-byte write.
    task automatic test_abort();
        for (int c = 0; c < 2; c++) begin
            int tgt, iv, at, cut;
            logic [PB-1:0] kept;
            tgt = (model_cur < 512) ? model_cur + 300 : model_cur - 300;
            iv  = (c == 0) ? 4 : 2;
            at  = (c == 0) ? 2 : 3;
            cut = (c == 0) ? 3 : 5;
            build_model(model_cur, tgt, 'h40, iv, 1);
            kept = e_duty[cut-1];
            do_start(tgt, 'h40, iv, 1);
            for (int t = 0; t < cut + 6; t++) begin
                logic          xw, xd, xb;
                logic [7:0]    xa, xdat;
                logic [PB-1:0] xdu;
                if (t < cut) begin
                    xw = e_wr[t]; xa = e_addr[t]; xdat = e_data[t]; xd = e_done[t]; xb = e_busy[t];
                    xdu = e_duty[t];
                end else begin
                    xw = 0; xa = 0; xdat = 0; xd = 0; xb = 0; xdu = kept;
                end
                n_tests++;
                if (p_write_o !== xw || p_addr_o !== xa || p_data_o !== xdat || done_o !== xd ||
                    busy_o !== xb || duty_o !== xdu) begin
                    n_fail++;
                    $display("FAIL abort%0d t=%0d: got wr=%b a=%h d=%h done=%b busy=%b duty=%h, want wr=%b a=%h d=%h done=%b busy=%b duty=%h",
                             c, t, p_write_o, p_addr_o, p_data_o, done_o, busy_o, duty_o,
                             xw, xa, xdat, xd, xb, xdu);
                end
                abort_i = (t == at);
                clk_step();
            end
            abort_i   = 1'b0;
            model_cur = int'(kept);
        end
    endtask

    task automatic test_reset_mid();
        int tgt;
        tgt = (model_cur < 512) ? model_cur + 300 : model_cur - 300;
        build_model(model_cur, tgt, 'h40, 4, 3);
        do_start(tgt, 'h40, 4, 3);
        for (int t = 0; t < 3; t++) begin
            n_tests++;
            if (p_write_o !== e_wr[t] || busy_o !== e_busy[t] || duty_o !== e_duty[t]) begin
                n_fail++;
                $display("FAIL pre_reset t=%0d: got wr=%b busy=%b duty=%h, want wr=%b busy=%b duty=%h",
                         t, p_write_o, busy_o, duty_o, e_wr[t], e_busy[t], e_duty[t]);
            end
            if (t < 2) clk_step();
        end
        nrst = 1'b0;
        #1;
        n_tests++;
        if ({busy_o, done_o, p_write_o, p_addr_o, p_data_o, duty_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b wr=%b addr=%h data=%h duty=%h, want all 0",
                     busy_o, done_o, p_write_o, p_addr_o, p_data_o, duty_o);
        end
        repeat (2) clk_step();
        nrst = 1'b1;
        for (int t = 0; t < 6; t++) begin
            clk_step();
            n_tests++;
            if ({busy_o, done_o, p_write_o, p_addr_o, p_data_o, duty_o} !== '0) begin
                n_fail++;
                $display("FAIL post_reset t=%0d: got busy=%b done=%b wr=%b addr=%h data=%h duty=%h, want all 0",
                         t, busy_o, done_o, p_write_o, p_addr_o, p_data_o, duty_o);
            end
        end
        model_cur = 0;
    endtask

    initial begin
        test_reset();
        test_ramps(12);
        test_abort();
        test_reset_mid();
        test_ramps(6);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
